// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store initiator.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword lane of a RAM word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] dout,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = '0;
    case (off)
      2'd0: b = dout[7:0];
      2'd1: b = dout[15:8];
      2'd2: b = dout[23:16];
      2'd3: b = dout[31:24];
      default: b = '0;
    endcase
    h = off[1] ? dout[31:16] : dout[15:0];

    data = '0;
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_BU:   data = {24'h0, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_HU:   data = {16'h0, h};
      F3_W:    data = dout;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one request at a time, converted to RAM strobes,
// with a registered response carrying extended load data or an error code.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  ram_ce,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  state_t state, state_nxt;

  logic                  accept;
  logic [1:0]            chk_err;
  logic [3:0]            we_mask;
  logic [31:0]           din_rep;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [3:0]            we_mask_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [31:0]           ram_din_q;
  logic [31:0]           rdata_q;
  logic [1:0]            err_q;
  logic [31:0]           load_data;

  assign accept = req_valid && req_ready;

  always_comb begin
    chk_err = ERR_NONE;
    if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111 ||
        (req_we && req_funct3[2]))
      chk_err = ERR_ILLEGAL;
    else if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
             (req_funct3 == F3_W && req_addr[1:0] != 2'b00))
      chk_err = ERR_MISALIGN;
    else if (|req_addr[31:ADDR_WIDTH+2])
      chk_err = ERR_RANGE;
  end

  always_comb begin
    we_mask = '0;
    din_rep = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        we_mask = 4'b0001 << req_addr[1:0];
        din_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        we_mask = 4'b0011 << req_addr[1:0];
        din_rep = {2{req_wdata[15:0]}};
      end
      default: we_mask = 4'b1111;
    endcase
    if (!req_we)
      we_mask = '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = (chk_err == ERR_NONE) ? S_ACCESS : S_RESP;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   if (resp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // RAM address/data are registered at accept so they hold between accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      we_mask_q  <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      rdata_q    <= '0;
      err_q      <= ERR_NONE;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        off_q   <= req_addr[1:0];
        err_q   <= chk_err;
        rdata_q <= '0;
        if (chk_err == ERR_NONE) begin
          we_mask_q  <= we_mask;
          ram_addr_q <= req_addr[ADDR_WIDTH+1:2];
          ram_din_q  <= din_rep;
        end
      end
      if (state == S_ACCESS)
        rdata_q <= we_q ? '0 : load_data;
    end
  end

  lsu_load_align u_align (
    .dout   (ram_dout),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign ram_ce     = (state == S_ACCESS) && !rst;
  assign ram_we     = ram_ce ? we_mask_q : 4'b0000;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;

endmodule
